// File: rtl/led_blink_sched.sv
// Purpose: two-requester LED blink scheduler driving one shared LED, round-robin on ties.
// Latency: grant and done pulses appear the clock after the IDLE decision; the LED follows the state one clock later.
// Backpressure: requests are held by the requester until gnt pulses; requests seen outside IDLE are ignored.
//
// Ports:
//   clk      - single clock, all state updates on the rising edge
//   reset    - asynchronous active-high reset
//   req      - per-requester blink request, held high until granted
//   blinks0  - blink count of requester 0, captured when requester 0 is granted
//   blinks1  - blink count of requester 1, captured when requester 1 is granted
//   gnt      - one-hot, one-cycle pulse acknowledging acceptance of a request
//   done     - one-hot, one-cycle pulse when the owner's sequence completes
//   busy     - high while a blink sequence is in progress
//   led_out  - shared LED drive, high only during ON phases
module led_blink_sched #(
    parameter int PRESCALE_W = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [3:0] blinks0,
    input  logic [3:0] blinks1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy,
    output logic       led_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t                state;
    logic [PRESCALE_W-1:0] phase;
    logic [3:0]            remaining;
    logic                  owner;
    logic                  last_owner;
    // Set when GAP finishes; the done pulse for owner is issued in the
    // first IDLE cycle that follows.
    logic                  done_pend;

    logic                  phase_end;
    logic                  rr_last;
    logic                  sel;
    logic                  sel_vld;
    logic [3:0]            sel_blinks;
    logic                  take;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    assign phase_end = (phase == {PRESCALE_W{1'b1}});

    // While a completion is pending, last_owner has not been written yet,
    // so arbitrate against the owner that is finishing right now.
    assign rr_last = done_pend ? owner : last_owner;

    always_comb begin
        sel     = 1'b0;
        sel_vld = 1'b0;
        case (req)
            2'b01: begin
                sel     = 1'b0;
                sel_vld = 1'b1;
            end
            2'b10: begin
                sel     = 1'b1;
                sel_vld = 1'b1;
            end
            2'b11: begin
                sel     = ~rr_last;
                sel_vld = 1'b1;
            end
            default: begin
                sel     = 1'b0;
                sel_vld = 1'b0;
            end
        endcase
    end

    assign sel_blinks = sel ? blinks1 : blinks0;

    // A zero-count grant completes immediately. If it landed in the same
    // cycle as a pending completion it would need a second done pulse, so
    // it is held off for one cycle to keep done one-hot.
    assign take = (state == IDLE) && sel_vld && !(done_pend && (sel_blinks == 4'd0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            remaining  <= 4'd0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            done_pend  <= 1'b0;
            gnt        <= 2'b00;
            done       <= 2'b00;
            busy       <= 1'b0;
            led_out    <= 1'b0;
        end else begin
            gnt     <= 2'b00;
            done    <= 2'b00;
            busy    <= (state != IDLE);
            led_out <= (state == ON);

            case (state)
                IDLE: begin
                    phase <= '0;
                    if (done_pend) begin
                        done       <= onehot(owner);
                        last_owner <= owner;
                        done_pend  <= 1'b0;
                    end
                    if (take) begin
                        gnt       <= onehot(sel);
                        owner     <= sel;
                        remaining <= sel_blinks;
                        if (sel_blinks != 4'd0) begin
                            state <= ON;
                        end else begin
                            done       <= onehot(sel);
                            last_owner <= sel;
                        end
                    end
                end

                ON: begin
                    if (phase_end) begin
                        phase     <= '0;
                        remaining <= remaining - 4'd1;
                        state     <= OFF;
                    end else begin
                        phase <= phase + PRESCALE_W'(1);
                    end
                end

                OFF: begin
                    if (phase_end) begin
                        phase <= '0;
                        state <= (remaining != 4'd0) ? ON : GAP;
                    end else begin
                        phase <= phase + PRESCALE_W'(1);
                    end
                end

                GAP: begin
                    if (phase_end) begin
                        phase     <= '0;
                        state     <= IDLE;
                        done_pend <= 1'b1;
                    end else begin
                        phase <= phase + PRESCALE_W'(1);
                    end
                end

                default: begin
                    phase <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_sched.sv
module tb_led_blink_sched;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [3:0] blinks0;
    logic [3:0] blinks1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic       led_out;

    int checks;
    int errors;

    led_blink_sched #(.PRESCALE_W(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .blinks0 (blinks0),
        .blinks1 (blinks1),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .led_out (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge; cycle k of a
    // sequence is the k-th sample after the sample that shows gnt.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Phase length 4: blink j is ON in cycles 1+8j..4+8j after the grant,
    // sequence busy for 8n+4 cycles, done in cycle 8n+5.
    function automatic logic exp_led(input int n, input int k);
        for (int j = 0; j < n; j++) begin
            if (k >= 1 + 8 * j && k <= 4 + 8 * j) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic exp_busy(input int n, input int k);
        return (k >= 1 && k <= 8 * n + 4);
    endfunction

    task automatic test_reset();
        reset   = 1'b1;
        req     = 2'b00;
        blinks0 = 4'd0;
        blinks1 = 4'd0;
        #2;
        tick();
        tick();
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b want 00", gnt); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (led_out !== 1'b0) begin errors++; $display("FAIL reset_led got %b want 0", led_out); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req     = 2'b01;
        blinks0 = 4'd1;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL single_gnt got %b want 01", gnt); end
        checks++; if (led_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_t0 led=%b busy=%b want 0 0", led_out, busy); end
        req = 2'b00;
        for (int k = 1; k <= 14; k++) begin
            tick();
            checks++; if (led_out !== exp_led(1, k)) begin errors++; $display("FAIL single_led k=%0d got %b want %b", k, led_out, exp_led(1, k)); end
            checks++; if (busy !== exp_busy(1, k)) begin errors++; $display("FAIL single_busy k=%0d got %b want %b", k, busy, exp_busy(1, k)); end
            checks++; if (done !== ((k == 13) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL single_done k=%0d got %b", k, done); end
            checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL single_nognt k=%0d got %b want 00", k, gnt); end
        end
    endtask

    task automatic test_multi();
        req     = 2'b10;
        blinks1 = 4'd3;
        tick();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL multi_gnt got %b want 10", gnt); end
        req = 2'b00;
        for (int k = 1; k <= 29; k++) begin
            tick();
            checks++; if (led_out !== exp_led(3, k)) begin errors++; $display("FAIL multi_led k=%0d got %b want %b", k, led_out, exp_led(3, k)); end
            checks++; if (busy !== exp_busy(3, k)) begin errors++; $display("FAIL multi_busy k=%0d got %b want %b", k, busy, exp_busy(3, k)); end
            checks++; if (done !== ((k == 29) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL multi_done k=%0d got %b", k, done); end
        end
    endtask

    task automatic test_zero();
        req     = 2'b01;
        blinks0 = 4'd0;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL zero_gnt got %b want 01", gnt); end
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL zero_done got %b want 01", done); end
        req = 2'b00;
        for (int k = 0; k < 4; k++) begin
            checks++; if (busy !== 1'b0 || led_out !== 1'b0) begin errors++; $display("FAIL zero_idle k=%0d busy=%b led=%b want 0 0", k, busy, led_out); end
            tick();
        end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL zero_done_once got %b want 00", done); end
    endtask

    task automatic test_ignored();
        req     = 2'b01;
        blinks0 = 4'd2;
        blinks1 = 4'd1;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL ign_gnt0 got %b want 01", gnt); end
        // Requester 1 asks while busy; requester 0's count changes after capture.
        req     = 2'b10;
        blinks0 = 4'd5;
        for (int k = 1; k <= 21; k++) begin
            tick();
            checks++; if (led_out !== exp_led(2, k)) begin errors++; $display("FAIL ign_led k=%0d got %b want %b", k, led_out, exp_led(2, k)); end
            checks++; if (gnt !== ((k == 21) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL ign_gnt k=%0d got %b", k, gnt); end
            checks++; if (done !== ((k == 21) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL ign_done k=%0d got %b", k, done); end
        end
        req = 2'b00;
        for (int k = 1; k <= 13; k++) begin
            tick();
            checks++; if (led_out !== exp_led(1, k)) begin errors++; $display("FAIL ign_led1 k=%0d got %b want %b", k, led_out, exp_led(1, k)); end
            checks++; if (done !== ((k == 13) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL ign_done1 k=%0d got %b", k, done); end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] prev;
        logic [1:0] next;
        reset   = 1'b1;
        req     = 2'b11;
        blinks0 = 4'd1;
        blinks1 = 4'd1;
        tick();
        reset = 1'b0;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rr_first got %b want 01", gnt); end
        prev = 2'b01;
        for (int g = 0; g < 3; g++) begin
            next = (prev == 2'b01) ? 2'b10 : 2'b01;
            for (int k = 1; k <= 13; k++) begin
                tick();
                checks++; if (gnt !== ((k == 13) ? next : 2'b00)) begin errors++; $display("FAIL rr_gnt g=%0d k=%0d got %b want %b", g, k, gnt, (k == 13) ? next : 2'b00); end
                checks++; if (done !== ((k == 13) ? prev : 2'b00)) begin errors++; $display("FAIL rr_done g=%0d k=%0d got %b want %b", g, k, done, (k == 13) ? prev : 2'b00); end
            end
            prev = next;
        end
        req = 2'b00;
        for (int k = 1; k <= 13; k++) tick();
        checks++; if (done !== 2'b10) begin errors++; $display("FAIL rr_last_done got %b want 10", done); end
    endtask

    task automatic test_reset_mid();
        // Zero-count grant to requester 0 makes it the last owner.
        req     = 2'b01;
        blinks0 = 4'd0;
        tick();
        req     = 2'b01;
        blinks0 = 4'd2;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL mid_gnt got %b want 01", gnt); end
        req = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 3) begin
                checks++; if (led_out !== 1'b1) begin errors++; $display("FAIL mid_led_on got %b want 1", led_out); end
            end
        end
        reset = 1'b1;
        #1;
        checks++; if (led_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_async led=%b busy=%b want 0 0", led_out, busy); end
        tick();
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            checks++; if (done !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL mid_nodone k=%0d done=%b busy=%b", k, done, busy); end
        end
        // last_owner restored to 1, so requester 0 must win the tie.
        req     = 2'b11;
        blinks0 = 4'd1;
        blinks1 = 4'd1;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL mid_tie got %b want 01", gnt); end
        req = 2'b00;
        for (int k = 1; k <= 13; k++) begin
            tick();
            checks++; if (led_out !== exp_led(1, k)) begin errors++; $display("FAIL mid_led k=%0d got %b want %b", k, led_out, exp_led(1, k)); end
            checks++; if (done !== ((k == 13) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL mid_done k=%0d got %b", k, done); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_multi();
        test_zero();
        test_ignored();
        test_round_robin();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
